// File: rtl/seq_alu_issuer_pkg.sv
// Shared types for the sequential-ALU issuer: opcode encoding and defaults.
// Imported by the command FIFO and the issuer top.
package SEQ_ALU_PACKAGE;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        AND = 2'd2,
        OR  = 2'd3
    } opcode_e;

    localparam int ISSUER_DEPTH_DEF = 4;
    localparam int OPC_W            = $bits(opcode_e);

    // Packed command width for a given operand width.
    function automatic int cmd_w(input int width);
        return OPC_W + 2 * width;
    endfunction

endpackage

// File: rtl/seq_alu_issuer_cmd_fifo.sv
// Command FIFO for the issuer: DEPTH entries (power of two), head always visible.
// Pointers wrap modulo DEPTH; full/empty come from an occupancy counter.
module seq_alu_cmd_fifo
    import SEQ_ALU_PACKAGE::*;
#(
    parameter int DW    = 10,
    parameter int DEPTH = ISSUER_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] data_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage; cleared on reset so the head never drives X to the ALU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/seq_alu_issuer.sv
// Issues queued commands to a sequential ALU and captures results in order.
// Optional SEQ_ALU_ISSUER_STATS_EN adds an 8-bit wrapping issue counter.
module seq_alu_issuer
    import SEQ_ALU_PACKAGE::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = ISSUER_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  opcode_e          cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             alu_en,
    output opcode_e          alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH:0]   alu_c,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH:0]   res_data
`ifdef SEQ_ALU_ISSUER_STATS_EN
    ,
    output logic [7:0]       issue_cnt
`endif
);

    localparam int CW = cmd_w(WIDTH);

    logic [CW-1:0]  push_data, head;
    logic           fifo_full, fifo_empty;
    logic           issue, capture;
    logic           inflight_q, inflight_d;
    logic           res_valid_q, res_valid_d;
    logic [WIDTH:0] res_data_q, res_data_d;

    assign push_data = {cmd_opcode, cmd_a, cmd_b};

    seq_alu_cmd_fifo #(
        .DW    (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .pop_i   (issue),
        .data_i  (push_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    // The head is always presented; alu_en alone marks a real issue.
    assign alu_opcode = opcode_e'(head[CW-1 -: OPC_W]);
    assign alu_a      = head[2*WIDTH-1 -: WIDTH];
    assign alu_b      = head[WIDTH-1:0];

    assign cmd_ready = !fifo_full;
    assign capture   = inflight_q && (!res_valid_q || res_ready);
    assign issue     = !fifo_empty && (!inflight_q || capture);
    assign alu_en    = issue;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

    // Next state for the in-flight flag and the result register.
    always_comb begin
        inflight_d  = inflight_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        if (issue) begin
            inflight_d = 1'b1;
        end else if (capture) begin
            inflight_d = 1'b0;
        end
        if (capture) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_c;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            inflight_q  <= inflight_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

`ifdef SEQ_ALU_ISSUER_STATS_EN
    logic [7:0] issue_cnt_q;

    assign issue_cnt = issue_cnt_q;

    // Count issued commands, wrapping at 8 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt_q <= '0;
        end else if (issue) begin
            issue_cnt_q <= issue_cnt_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_alu_issuer.sv
// Self-checking bench for seq_alu_issuer with a behavioural ALU and scoreboard.
// Directed vectors cover latency, ordering, backpressure, throughput and reset.
module tb_seq_alu_issuer;
    import SEQ_ALU_PACKAGE::*;

    localparam int W = 4;

    typedef struct packed {
        opcode_e      op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } cmd_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    opcode_e      cmd_opcode = ADD;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic         alu_en;
    opcode_e      alu_opcode;
    logic [W-1:0] alu_a, alu_b;
    logic [W:0]   alu_c = '0;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [W:0]   res_data;
`ifdef SEQ_ALU_ISSUER_STATS_EN
    logic [7:0]   issue_cnt;
`endif

    always #5 clk = ~clk;

    seq_alu_issuer #(.WIDTH(W), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_en     (alu_en),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data)
`ifdef SEQ_ALU_ISSUER_STATS_EN
        ,
        .issue_cnt  (issue_cnt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    cmd_t       iss_q[$];
    logic [W:0] res_q[$];
    logic [W:0] got[$];
    cmd_t       c;
    logic [W:0] e;
    int         acc_cnt = 0;
    int         run_en = 0, max_en = 0, en_cnt = 0;
    int         run_rv = 0, max_rv = 0, rv_cnt = 0;

    function automatic logic [W:0] alu_ref(opcode_e op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            ADD:     return {1'b0, a} + {1'b0, b};
            SUB:     return {1'b0, a} - {1'b0, b};
            AND:     return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sequential ALU: result one cycle after alu_en, held otherwise.
    always @(posedge clk) begin
        if (alu_en) alu_c <= alu_ref(alu_opcode, alu_a, alu_b);
    end

    // Record every accepted command in program order.
    always @(posedge clk) begin
        if (rst && cmd_valid && cmd_ready) begin
            iss_q.push_back('{cmd_opcode, cmd_a, cmd_b});
            res_q.push_back(alu_ref(cmd_opcode, cmd_a, cmd_b));
            acc_cnt++;
        end
    end

    // Compare issued commands and delivered results against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (alu_en) begin
                if (iss_q.size() == 0) begin
                    check("alu_en_unexpected", {31'b0, alu_en}, 0);
                end else begin
                    c = iss_q.pop_front();
                    check("alu_opcode", alu_opcode, c.op);
                    check("alu_a", alu_a, c.a);
                    check("alu_b", alu_b, c.b);
                end
            end
            if (res_valid && res_ready) begin
                if (res_q.size() == 0) begin
                    check("res_unexpected", {31'b0, res_valid}, 0);
                end else begin
                    e = res_q.pop_front();
                    check("res_data", res_data, e);
                end
                got.push_back(res_data);
            end
            run_en = alu_en ? run_en + 1 : 0;
            run_rv = res_valid ? run_rv + 1 : 0;
            if (run_en > max_en) max_en = run_en;
            if (run_rv > max_rv) max_rv = run_rv;
            if (alu_en) en_cnt++;
            if (res_valid) rv_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rst = 1'b0;
        iss_q.delete();
        res_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic send(opcode_e op, logic [W-1:0] a, logic [W-1:0] b);
        logic r;
        r = 1'b0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        for (int i = 0; i < 40 && !r; i++) begin
            @(negedge clk);
            r = cmd_ready;
            tick();
        end
        if (!r) check("send_timeout", {31'b0, cmd_ready}, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_results(int n);
        for (int i = 0; i < 60 && got.size() < n; i++) tick();
        if (got.size() < n) check("result_timeout", got.size(), n);
    endtask

    initial begin
        int i;
        int acc0;
        logic r;

        do_reset();
        check("rst_res_valid", {31'b0, res_valid}, 0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 1);
        check("rst_alu_en", {31'b0, alu_en}, 0);
        check("rst_res_data", res_data, 0);

        // Latency: ADD F+1 accepted at edge k.
        res_ready = 1'b1;
        send(ADD, 4'hF, 4'h1);
        @(negedge clk);
        check("lat_alu_en", {31'b0, alu_en}, 1);
        @(negedge clk);
        check("lat_alu_en_once", {31'b0, alu_en}, 0);
        check("lat_res_early", {31'b0, res_valid}, 0);
        @(negedge clk);
        check("lat_res_valid", {31'b0, res_valid}, 1);
        check("lat_res_data", res_data, 5'h10);
        repeat (3) tick();

        // Ordered SUB / AND / OR with hand-computed results.
        got.delete();
        send(SUB, 4'h3, 4'h5);
        send(AND, 4'hC, 4'hA);
        send(OR, 4'hC, 4'hA);
        wait_results(3);
        if (got.size() >= 3) begin
            check("sub_res", got[0], 5'h1E);
            check("and_res", got[1], 5'h08);
            check("or_res", got[2], 5'h0E);
        end
        repeat (3) tick();

        // Backpressure: 8 commands offered with res_ready low.
        res_ready = 1'b0;
        acc0 = acc_cnt;
        i = 0;
        repeat (14) begin
            cmd_valid  = (i < 8);
            cmd_opcode = opcode_e'(i % 4);
            cmd_a      = W'(i + 9);
            cmd_b      = W'(i + 3);
            @(negedge clk);
            r = cmd_ready;
            tick();
            if (r && i < 8) i++;
        end
        check("bp_accepted", acc_cnt - acc0, 6);
        check("bp_cmd_ready", {31'b0, cmd_ready}, 0);
        cmd_valid = 1'b0;
        got.delete();
        res_ready = 1'b1;
        wait_results(6);
        repeat (5) tick();
        check("bp_result_count", got.size(), 6);
        if (got.size() >= 6) begin
            check("bp_first", got[0], 5'h0C);
            check("bp_last", got[5], 5'h06);
        end

        // Back-to-back stream of 10 with res_ready high.
        max_en = 0;
        max_rv = 0;
        for (int k = 0; k < 10; k++)
            send(opcode_e'(k % 4), W'(k), W'(15 - k));
        repeat (6) tick();
        check("b2b_alu_en_run", max_en, 10);
        check("b2b_res_valid_run", max_rv, 10);

        // Reset with one held, one in flight and three queued.
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            send(ADD, W'(k + 1), W'(k + 2));
        repeat (2) tick();
        check("pre_rst_res_valid", {31'b0, res_valid}, 1);
        check("pre_rst_cmd_ready", {31'b0, cmd_ready}, 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        iss_q.delete();
        res_q.delete();
        #1;
        check("mid_rst_res_valid", {31'b0, res_valid}, 0);
        check("mid_rst_alu_en", {31'b0, alu_en}, 0);
        check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 1);
        check("mid_rst_res_data", res_data, 0);
        tick();
        rst = 1'b1;
        res_ready = 1'b1;
        rv_cnt = 0;
        en_cnt = 0;
        repeat (10) tick();
        check("post_rst_res_valid", rv_cnt, 0);
        check("post_rst_alu_en", en_cnt, 0);

`ifdef SEQ_ALU_ISSUER_STATS_EN
        do_reset();
        check("stats_rst", issue_cnt, 0);
        for (int k = 0; k < 257; k++)
            send(ADD, W'(k), W'(k >> 4));
        repeat (5) tick();
        check("stats_257", issue_cnt, 1);
`endif

        check("scoreboard_drain", iss_q.size() + res_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu_issuer.md
SEQ_ALU_ISSUER -- requirements
Module: seq_alu_issuer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width; matches sequential-ALU operand width.
REQ-002 SHALL have parameter DEPTH, default 4, command FIFO entries; power of two, >= 2.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  upstream command present.
REQ-007 cmd_ready  output  1  issuer accepts command this cycle.
REQ-008 cmd_opcode  input  opcode_e  ADD/SUB/AND/OR from SEQ_ALU_PACKAGE.
REQ-009 cmd_a, cmd_b  input  WIDTH  operands.
REQ-010 alu_en  output  1  enable to sequential ALU, one cycle per issued command.
REQ-011 alu_opcode, alu_a, alu_b  output  opcode_e/WIDTH/WIDTH  FIFO-head command driven to ALU.
REQ-012 alu_c  input  WIDTH+1  ALU result, valid one cycle after alu_en, held stable while alu_en=0.
REQ-013 res_valid  output  1  result register occupied.
REQ-014 res_ready  input  1  downstream consumes result.
REQ-015 res_data  output  WIDTH+1  captured ALU result.

Function
REQ-016 Command accepted on rising edge when cmd_valid && cmd_ready; cmd_ready = !fifo_full (no pass-through on simultaneous pop).
REQ-017 Issue in a cycle SHALL occur when FIFO non-empty && (!inflight || capture); alu_en=1 that cycle, alu_* = FIFO head, head popped at edge.
REQ-018 alu_opcode/alu_a/alu_b SHALL be driven from FIFO head regardless; alu_en=0 when FIFO empty or issue blocked.
REQ-019 inflight SHALL set at the issue edge and clear at the capture edge unless a new issue occurs at that same edge.
REQ-020 capture = inflight && (!res_valid || res_ready); at capture edge res_data <= alu_c, res_valid <= 1.
REQ-021 res_valid SHALL clear on edge with res_valid && res_ready && !capture.
REQ-022 Blocked inflight result SHALL wait on alu_c (ALU holds C while alu_en=0); no result lost or duplicated.
REQ-023 Latency: command accepted at edge k into idle empty block -> alu_en high cycle after k -> res_valid high after edge k+2.
REQ-024 Steady-state throughput one command per cycle with res_ready=1.
REQ-025 Results SHALL leave in acceptance order; arithmetic wrap is the ALU's (WIDTH+1 bits, modulo).
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; full/empty from count of log2(DEPTH)+1 bits.

Reset
REQ-027 rst=0 SHALL asynchronously clear FIFO (empty), inflight=0, res_valid=0, res_data=0, alu_en=0; cmd_ready=1 after deassertion.
REQ-028 Reset mid-operation SHALL discard queued, inflight and held results; no res_valid pulse after release without new commands.

Configuration
REQ-029 Macro SEQ_ALU_ISSUER_STATS_EN defined: adds output issue_cnt (8 bits), increments per issued command, wraps 255->0, reset to 0.
REQ-030 Macro undefined: issue_cnt port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-031 opcode_e (ADD, SUB, AND, OR) SHALL stay in SEQ_ALU_PACKAGE; add ISSUER_DEPTH_DEF=4 constant there.
REQ-032 FIFO SHALL be sub-module seq_alu_cmd_fifo (push/pop/full/empty, head data); issue/capture control in seq_alu_issuer.

Verification
REQ-033 ADD a=4'hF b=4'h1, res_ready=1 -> alu_en one cycle, res_data=5'h10 res_valid after edge k+2.
REQ-034 SUB a=3 b=5 -> res_data=5'h1E; AND 4'hC,4'hA -> 5'h08; OR 4'hC,4'hA -> 5'h0E, in order.
REQ-035 res_ready=0, stream 8 commands -> exactly 6 accepted (1 result, 1 inflight, 4 FIFO) then cmd_ready=0; release res_ready -> 6 results in order, no loss.
REQ-036 Back-to-back 10 commands res_ready=1 -> alu_en high 10 consecutive cycles, 10 consecutive res_valid cycles.
REQ-037 Assert rst=0 with 3 queued and 1 inflight -> all outputs reset same cycle; after release res_valid stays 0.
REQ-038 SEQ_ALU_ISSUER_STATS_EN defined, 257 issues -> issue_cnt=1.
